// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, flush, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, flush, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined chunked add/subtract; one chunk of carry chain resolved per stage.
// Define PIPE_ADDER_FLAGS_EN to compute the ovf/zero flags (tied to 0 otherwise).
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic       clk,
    input logic       rst_n,
    pipe_adder_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    logic adv;
    logic take;

    assign adv          = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;
    assign take         = bus.in_valid & adv & !bus.flush;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // IW: operand bits not yet consumed on entry; RW: bits skewed onward
        localparam int IW = WIDTH - k * CW;
        localparam int RW = IW - CW;

        logic [IW-1:0]         a_in;
        logic [IW-1:0]         b_in;
        logic                  c_in;
        logic                  sub_in;
        logic                  v_in;
        logic [CW:0]           part;
        logic [(k+1)*CW-1:0]   s_nxt;
        logic [(k+1)*CW-1:0]   s_q;
        logic                  c_nxt;
        logic                  c_q;
        logic                  v_q;

        if (k == 0) begin : g_src
            assign a_in   = bus.a;
            assign b_in   = bus.b ^ {WIDTH{bus.sub}};
            assign c_in   = bus.cin ^ bus.sub;
            assign sub_in = bus.sub;
            assign v_in   = take;
            assign s_nxt  = part[CW-1:0];
        end else begin : g_src
            assign a_in   = g_st[k-1].g_skew.a_q;
            assign b_in   = g_st[k-1].g_skew.b_q;
            assign c_in   = g_st[k-1].c_q;
            assign sub_in = g_st[k-1].g_skew.sub_q;
            assign v_in   = g_st[k-1].v_q;
            assign s_nxt  = {part[CW-1:0], g_st[k-1].s_q};
        end

        assign part = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

        // last stage registers the architectural carry/borrow directly
        if (k == STAGES - 1) begin : g_co
            assign c_nxt = part[CW] ^ sub_in;
        end else begin : g_co
            assign c_nxt = part[CW];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else begin
                if (bus.flush)
                    v_q <= 1'b0;
                else if (adv)
                    v_q <= v_in;
                if (adv) begin
                    c_q <= c_nxt;
                    s_q <= s_nxt;
                end
            end
        end

        if (RW > 0) begin : g_skew
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
            logic          sub_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else if (adv) begin
                    a_q   <= a_in[IW-1:CW];
                    b_q   <= b_in[IW-1:CW];
                    sub_q <= sub_in;
                end
            end
        end

`ifdef PIPE_ADDER_FLAGS_EN
        logic z_in;
        logic z_q;

        if (k == 0) begin : g_zi
            assign z_in = 1'b1;
        end else begin : g_zi
            assign z_in = g_st[k-1].z_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                z_q <= 1'b0;
            else if (adv)
                z_q <= z_in & (part[CW-1:0] == '0);
        end

        // top chunk lives here, so sign bits of a, effective b and sum are local
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ovf_q <= 1'b0;
                else if (adv)
                    ovf_q <= (a_in[IW-1] == b_in[IW-1]) & (part[CW-1] != a_in[IW-1]);
            end
        end
`endif
    end

    assign bus.out_valid = g_st[STAGES-1].v_q;
    assign bus.sum       = g_st[STAGES-1].s_q;
    assign bus.cout      = g_st[STAGES-1].c_q;

`ifdef PIPE_ADDER_FLAGS_EN
    assign bus.ovf  = g_st[STAGES-1].g_ovf.ovf_q;
    assign bus.zero = g_st[STAGES-1].z_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

endmodule
